// File: rtl/adc_readout_fsm_pkg.sv
`default_nettype none
// ==========================================================================
// adc_readout_fsm_pkg : shared encodings for the ADC readout sequencer (rev 1.0)
// ==========================================================================
package adc_readout_fsm_pkg;

    // The state encoding is the fsm_stat debug code, so the state register drives it directly.
    typedef enum logic [7:0] {
        ST_IDLE    = 8'h01,
        ST_ACK     = 8'h02,
        ST_SETTLE  = 8'h04,
        ST_START   = 8'h08,
        ST_CONV    = 8'h10,
        ST_NEXT    = 8'h20,
        ST_DONE    = 8'h40,
        ST_RELEASE = 8'h80
    } state_e;

    localparam logic CDS_SIGNAL = 1'b0;
    localparam logic CDS_RESET  = 1'b1;

    localparam int C_SETTLE_W = 16;
    localparam int C_FRAME_W  = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_readout_fsm_handshake_sync.sv
`default_nettype none
// ==========================================================================
// handshake_sync : 2-flop level synchronizer, async active-low reset (rev 1.0)
// ==========================================================================
module handshake_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/adc_readout_fsm.sv
`default_nettype none
// ==========================================================================
// adc_readout_fsm : row-by-row CDS readout sequencer with 4-phase handshake (rev 1.0)
// ==========================================================================
module adc_readout_fsm
    import adc_readout_fsm_pkg::*;
#(
    parameter int C_NUM_ROWS     = 160,
    parameter int C_ROW_W        = 8,
    parameter int C_CONV_TIMEOUT = 1024
) (
    input  logic               CLK_ADC,
    input  logic               RESET_B,
    input  logic               FSMIND1,
    output logic               FSMIND1ACK,
    output logic               FSMIND0,
    input  logic               FSMIND0ACK,
    input  logic [15:0]        T_SETTLE,
    input  logic               ADC_BUSY,
    output logic               ADC_START,
    output logic               CDS_PHASE,
    output logic               ROW_SEL,
    output logic [C_ROW_W-1:0] ROW_ADDR,
    output logic [31:0]        FRAME_CNT,
    output logic               CONV_ERR,
    output logic [7:0]         fsm_stat
);

    // The counter must reach C_CONV_TIMEOUT+1 and also the 2-cycle minimum.
    localparam int C_TO_W = ((clog2(C_CONV_TIMEOUT) + 1) < 2) ? 2 : (clog2(C_CONV_TIMEOUT) + 1);

    localparam logic [C_ROW_W-1:0] C_LAST_ROW = C_ROW_W'(C_NUM_ROWS - 1);
    localparam logic [C_TO_W-1:0]  C_TO_LIM   = C_TO_W'(C_CONV_TIMEOUT);
    localparam logic [C_TO_W-1:0]  C_CONV_MIN = C_TO_W'(2);

    logic s1;
    logic s0a;

    state_e                  state_q;
    logic                    fsmind1ack_q;
    logic                    fsmind0_q;
    logic                    adc_start_q;
    logic                    cds_phase_q;
    logic                    row_sel_q;
    logic [C_ROW_W-1:0]      row_addr_q;
    logic [C_FRAME_W-1:0]    frame_cnt_q;
    logic                    conv_err_q;
    logic [C_SETTLE_W-1:0]   settle_cnt_q;
    logic [C_TO_W-1:0]       conv_cnt_q;

    logic [C_SETTLE_W-1:0]   settle_len_d;
    logic                    conv_ok_d;
    logic                    conv_to_d;

    handshake_sync u_sync_fsmind1 (
        .clk_i  (CLK_ADC),
        .rst_ni (RESET_B),
        .d_i    (FSMIND1),
        .q_o    (s1)
    );

    handshake_sync u_sync_fsmind0ack (
        .clk_i  (CLK_ADC),
        .rst_ni (RESET_B),
        .d_i    (FSMIND0ACK),
        .q_o    (s0a)
    );

    assign settle_len_d = (T_SETTLE == 16'd0) ? 16'd1 : T_SETTLE;
    assign conv_ok_d    = (conv_cnt_q >= C_CONV_MIN) && !ADC_BUSY;
    assign conv_to_d    = ADC_BUSY && (conv_cnt_q > C_TO_LIM);

    always_ff @(posedge CLK_ADC or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q      <= ST_IDLE;
            fsmind1ack_q <= 1'b0;
            fsmind0_q    <= 1'b0;
            adc_start_q  <= 1'b0;
            cds_phase_q  <= CDS_SIGNAL;
            row_sel_q    <= 1'b0;
            row_addr_q   <= '0;
            frame_cnt_q  <= '0;
            conv_err_q   <= 1'b0;
            settle_cnt_q <= '0;
            conv_cnt_q   <= '0;
        end else begin
            adc_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s1) begin
                        fsmind1ack_q <= 1'b1;
                        state_q      <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    fsmind1ack_q <= 1'b1;
                    row_addr_q   <= '0;
                    cds_phase_q  <= CDS_SIGNAL;
                    row_sel_q    <= 1'b1;
                    settle_cnt_q <= settle_len_d;
                    state_q      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q <= 16'd1) begin
                        adc_start_q <= 1'b1;
                        state_q     <= ST_START;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 16'd1;
                    end
                end
                ST_START: begin
                    conv_cnt_q <= C_TO_W'(1);
                    state_q    <= ST_CONV;
                end
                ST_CONV: begin
                    // A stuck ADC is flagged and then treated as a finished conversion.
                    if (conv_ok_d || conv_to_d) begin
                        if (conv_to_d) begin
                            conv_err_q <= 1'b1;
                        end
                        if (cds_phase_q == CDS_SIGNAL) begin
                            cds_phase_q <= CDS_RESET;
                            adc_start_q <= 1'b1;
                            state_q     <= ST_START;
                        end else begin
                            cds_phase_q <= CDS_SIGNAL;
                            row_sel_q   <= 1'b0;
                            state_q     <= ST_NEXT;
                        end
                    end else begin
                        conv_cnt_q <= conv_cnt_q + C_TO_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (row_addr_q == C_LAST_ROW) begin
                        fsmind0_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        row_addr_q   <= row_addr_q + C_ROW_W'(1);
                        row_sel_q    <= 1'b1;
                        settle_cnt_q <= settle_len_d;
                        state_q      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    if (s0a) begin
                        fsmind0_q    <= 1'b0;
                        fsmind1ack_q <= 1'b0;
                        state_q      <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!s1) begin
                        frame_cnt_q <= frame_cnt_q + 32'd1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    fsmind1ack_q <= 1'b0;
                    fsmind0_q    <= 1'b0;
                    adc_start_q  <= 1'b0;
                    cds_phase_q  <= CDS_SIGNAL;
                    row_sel_q    <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign FSMIND1ACK = fsmind1ack_q;
    assign FSMIND0    = fsmind0_q;
    assign ADC_START  = adc_start_q;
    assign CDS_PHASE  = cds_phase_q;
    assign ROW_SEL    = row_sel_q;
    assign ROW_ADDR   = row_addr_q;
    assign FRAME_CNT  = frame_cnt_q;
    assign CONV_ERR   = conv_err_q;
    assign fsm_stat   = state_q;

endmodule

`default_nettype wire
